// File: rtl/arbiter_in_download.sv
// Round-robin arbiter of the IN request/reply FIFOs onto the download flit bus.
// Define ARB_PKT_CNT_EN to add per-target completed-packet counters.
module arbiter_in_download #(
  parameter logic [4:0] INSTREP_CMD   = 5'b10100,
  parameter logic [4:0] NACKREP_CMD   = 5'b10101,
  parameter logic [4:0] SCFLUREP_CMD  = 5'b11100,
  parameter logic [4:0] C2CINVREP_CMD = 5'b11011
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] req_flit,
  input  logic        v_req_flit,
  input  logic [1:0]  req_ctrl,
  output logic        req_fifo_pop,
  input  logic [15:0] rep_flit,
  input  logic        v_rep_flit,
  input  logic [1:0]  rep_ctrl,
  output logic        rep_fifo_pop,
  input  logic [1:0]  dc_download_state,
  input  logic [1:0]  ic_download_state,
  input  logic [1:0]  mem_download_state,
  output logic [15:0] flit_out,
  output logic [1:0]  ctrl_out,
  output logic        v_flit_dc,
  output logic        v_flit_ic,
  output logic        v_flit_mem,
  output logic [1:0]  arb_state
`ifdef ARB_PKT_CNT_EN
  ,
  output logic [15:0] dc_pkt_cnt,
  output logic [15:0] ic_pkt_cnt,
  output logic [15:0] mem_pkt_cnt
`endif
);

  typedef enum logic [1:0] {
    IDLE     = 2'b00,
    REQ_LOCK = 2'b01,
    REP_LOCK = 2'b10
  } state_t;

  localparam logic [1:0] TGT_DC  = 2'b01;
  localparam logic [1:0] TGT_IC  = 2'b10;
  localparam logic [1:0] TGT_MEM = 2'b11;
  localparam logic SRC_REQ = 1'b0;

  state_t     state;
  logic       last_grant;
  logic [1:0] target_reg;

  logic [4:0] rep_cmd;
  logic [1:0] rep_tgt;
  logic [1:0] rep_tgt_st;
  logic       req_elig;
  logic       rep_elig;
  logic       grant_req;
  logic       grant_rep;
  logic       sel_req;
  logic       sel_rep;
  logic       rep_single;
  logic       head_single;
  logic       fwd;
  logic       last_flit;
  logic [1:0] tgt;

  assign rep_cmd    = rep_flit[9:5];
  assign rep_tgt    = (rep_cmd == INSTREP_CMD) ? TGT_IC : TGT_DC;
  assign rep_tgt_st = (rep_tgt == TGT_IC) ? ic_download_state
                                          : dc_download_state;
  assign rep_single = rep_cmd inside {NACKREP_CMD, SCFLUREP_CMD,
                                      C2CINVREP_CMD};

  assign req_elig = v_req_flit && (mem_download_state == 2'b00);
  assign rep_elig = v_rep_flit && (rep_tgt_st == 2'b00);

  // On a tie the source that did not win last time takes the grant.
  assign grant_rep = (state == IDLE) && rep_elig &&
                     (!req_elig || last_grant == SRC_REQ);
  assign grant_req = (state == IDLE) && req_elig && !grant_rep;

  assign sel_req = grant_req || (state == REQ_LOCK && v_req_flit);
  assign sel_rep = grant_rep || (state == REP_LOCK && v_rep_flit);
  assign fwd     = sel_req || sel_rep;

  always_comb begin
    req_fifo_pop = 1'b0;
    rep_fifo_pop = 1'b0;
    flit_out     = 16'h0000;
    ctrl_out     = 2'b00;
    tgt          = 2'b00;
    unique case (1'b1)
      sel_req: begin
        req_fifo_pop = 1'b1;
        flit_out     = req_flit;
        ctrl_out     = req_ctrl;
        tgt          = grant_req ? TGT_MEM : target_reg;
      end
      sel_rep: begin
        rep_fifo_pop = 1'b1;
        flit_out     = rep_flit;
        ctrl_out     = rep_ctrl;
        tgt          = grant_rep ? rep_tgt : target_reg;
      end
      default: ;
    endcase
  end

  assign v_flit_dc  = (tgt == TGT_DC);
  assign v_flit_ic  = (tgt == TGT_IC);
  assign v_flit_mem = (tgt == TGT_MEM);
  assign arb_state  = state;

  assign head_single = grant_req ? (req_ctrl == 2'b11)
                                 : (rep_ctrl == 2'b11 || rep_single);
  assign last_flit   = fwd && ((state == IDLE) ? head_single
                                               : (ctrl_out == 2'b11));

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      last_grant <= SRC_REQ;
      target_reg <= 2'b00;
    end else begin
      unique case (state)
        IDLE: begin
          if (fwd) begin
            last_grant <= grant_rep;
            target_reg <= tgt;
            if (!head_single)
              state <= grant_rep ? REP_LOCK : REQ_LOCK;
          end
        end
        default: begin
          if (fwd && ctrl_out == 2'b11)
            state <= IDLE;
        end
      endcase
    end
  end

`ifdef ARB_PKT_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      dc_pkt_cnt  <= 16'h0000;
      ic_pkt_cnt  <= 16'h0000;
      mem_pkt_cnt <= 16'h0000;
    end else if (last_flit) begin
      unique case (tgt)
        TGT_DC:
          if (dc_pkt_cnt != 16'hFFFF)
            dc_pkt_cnt <= dc_pkt_cnt + 16'd1;
        TGT_IC:
          if (ic_pkt_cnt != 16'hFFFF)
            ic_pkt_cnt <= ic_pkt_cnt + 16'd1;
        TGT_MEM:
          if (mem_pkt_cnt != 16'hFFFF)
            mem_pkt_cnt <= mem_pkt_cnt + 16'd1;
        default: ;
      endcase
    end
  end
`endif

endmodule

// File: tb/tb_arbiter_in_download.sv
// Randomized bench for arbiter_in_download against a packet-level model.
// FIFOs are modelled as queues of whole packets; engine states are random.
module tb_arbiter_in_download;

  localparam logic [4:0] INSTREP = 5'b10100;
  localparam logic [4:0] NACKREP = 5'b10101;
  localparam logic [4:0] SCFLU   = 5'b11100;
  localparam logic [4:0] C2CINV  = 5'b11011;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] req_flit;
  logic        v_req_flit;
  logic [1:0]  req_ctrl;
  logic        req_fifo_pop;
  logic [15:0] rep_flit;
  logic        v_rep_flit;
  logic [1:0]  rep_ctrl;
  logic        rep_fifo_pop;
  logic [1:0]  dc_download_state;
  logic [1:0]  ic_download_state;
  logic [1:0]  mem_download_state;
  logic [15:0] flit_out;
  logic [1:0]  ctrl_out;
  logic        v_flit_dc;
  logic        v_flit_ic;
  logic        v_flit_mem;
  logic [1:0]  arb_state;
`ifdef ARB_PKT_CNT_EN
  logic [15:0] dc_pkt_cnt;
  logic [15:0] ic_pkt_cnt;
  logic [15:0] mem_pkt_cnt;
`endif

  always #5 clk = ~clk;

  arbiter_in_download dut (
    .clk                (clk),
    .rst                (rst),
    .req_flit           (req_flit),
    .v_req_flit         (v_req_flit),
    .req_ctrl           (req_ctrl),
    .req_fifo_pop       (req_fifo_pop),
    .rep_flit           (rep_flit),
    .v_rep_flit         (v_rep_flit),
    .rep_ctrl           (rep_ctrl),
    .rep_fifo_pop       (rep_fifo_pop),
    .dc_download_state  (dc_download_state),
    .ic_download_state  (ic_download_state),
    .mem_download_state (mem_download_state),
    .flit_out           (flit_out),
    .ctrl_out           (ctrl_out),
    .v_flit_dc          (v_flit_dc),
    .v_flit_ic          (v_flit_ic),
    .v_flit_mem         (v_flit_mem),
    .arb_state          (arb_state)
`ifdef ARB_PKT_CNT_EN
    ,
    .dc_pkt_cnt         (dc_pkt_cnt),
    .ic_pkt_cnt         (ic_pkt_cnt),
    .mem_pkt_cnt        (mem_pkt_cnt)
`endif
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  // Each entry is {ctrl, flit}.
  logic [17:0] req_q[$];
  logic [17:0] rep_q[$];

  // Model state: lock_src -1 none, 0 request, 1 reply; targets 0 dc 1 ic 2 mem.
  int lock_src;
  int lock_tgt;
  bit last_rep;
  int cnt[3];

  function automatic bit is_single_cmd(logic [4:0] c);
    return c == NACKREP || c == SCFLU || c == C2CINV;
  endfunction

  task automatic push_pkt(bit rep);
    int          len;
    int          k;
    logic [4:0]  cmd;
    logic [15:0] f;
    logic [1:0]  c;
    k = $urandom_range(0, 4);
    case (k)
      0: cmd = INSTREP;
      1: cmd = NACKREP;
      2: cmd = SCFLU;
      3: cmd = C2CINV;
      default: cmd = 5'($urandom);
    endcase
    if (!rep) cmd = 5'($urandom);
    len = (rep && is_single_cmd(cmd)) ? 1 : $urandom_range(1, 5);
    for (int i = 0; i < len; i++) begin
      f = 16'($urandom);
      if (i == 0) f[9:5] = cmd;
      if (i == 0 && rep && is_single_cmd(cmd))
        c = $urandom_range(0, 1) ? 2'b01 : 2'b11;
      else if (i == 0)
        c = (len == 1) ? 2'b11 : 2'b01;
      else
        c = (i == len - 1) ? 2'b11 : 2'b10;
      if (rep) rep_q.push_back({c, f});
      else     req_q.push_back({c, f});
    end
  endtask

  task automatic drive(int cyc);
    bit allidle;
    allidle = cyc < 30;
    v_req_flit = req_q.size() > 0 && $urandom_range(0, 9) < 7;
    v_rep_flit = rep_q.size() > 0 && $urandom_range(0, 9) < 7;
    {req_ctrl, req_flit} = v_req_flit ? req_q[0] : 18'($urandom);
    {rep_ctrl, rep_flit} = v_rep_flit ? rep_q[0] : 18'($urandom);
    dc_download_state  = (allidle || $urandom_range(0, 9) < 7)
                         ? 2'b00 : 2'($urandom_range(1, 3));
    ic_download_state  = (allidle || $urandom_range(0, 9) < 7)
                         ? 2'b00 : 2'($urandom_range(1, 3));
    mem_download_state = (allidle || $urandom_range(0, 9) < 7)
                         ? 2'b00 : 2'($urandom_range(1, 3));
  endtask

  task automatic step();
    int          src;
    int          tgt;
    int          rt;
    bit          qo;
    bit          ro;
    bit          done;
    logic [1:0]  st[3];
    logic [17:0] e;
    st[0] = dc_download_state;
    st[1] = ic_download_state;
    st[2] = mem_download_state;
    src = -1;
    tgt = 0;
    if (lock_src < 0) begin
      rt = (v_rep_flit && rep_q[0][9:5] == INSTREP) ? 1 : 0;
      qo = v_req_flit && st[2] == 2'b00;
      ro = v_rep_flit && st[rt] == 2'b00;
      if (qo && ro) src = last_rep ? 0 : 1;
      else if (qo)  src = 0;
      else if (ro)  src = 1;
      tgt = (src == 0) ? 2 : rt;
    end else begin
      if ((lock_src == 0 && v_req_flit) || (lock_src == 1 && v_rep_flit))
        src = lock_src;
      tgt = lock_tgt;
    end
    e = (src == 0) ? req_q[0] : (src == 1) ? rep_q[0] : 18'h0;

    chk("arb_state", 32'(arb_state),
        (lock_src < 0) ? 0 : (lock_src == 0) ? 1 : 2);
    chk("pop", {req_fifo_pop, rep_fifo_pop}, {src == 0, src == 1});
    chk("valid", {v_flit_dc, v_flit_ic, v_flit_mem},
        (src < 0) ? 32'd0 : (32'd4 >> tgt));
    chk("flit", 32'(flit_out), 32'(e[15:0]));
    chk("ctrl", 32'(ctrl_out), 32'(e[17:16]));
`ifdef ARB_PKT_CNT_EN
    chk("dc_cnt",  32'(dc_pkt_cnt),  cnt[0]);
    chk("ic_cnt",  32'(ic_pkt_cnt),  cnt[1]);
    chk("mem_cnt", 32'(mem_pkt_cnt), cnt[2]);
`endif

    if (src >= 0) begin
      if (lock_src < 0) begin
        done = e[17:16] == 2'b11 || (src == 1 && is_single_cmd(e[9:5]));
        last_rep = (src == 1);
        if (!done) begin
          lock_src = src;
          lock_tgt = tgt;
        end
      end else begin
        done = e[17:16] == 2'b11;
        if (done) lock_src = -1;
      end
      if (done && cnt[tgt] < 65535) cnt[tgt]++;
      if (src == 0) void'(req_q.pop_front());
      else          void'(rep_q.pop_front());
    end
  endtask

  initial begin
    bit do_rst;
    rst = 1'b1;
    v_req_flit = 1'b0;
    v_rep_flit = 1'b0;
    req_flit = 16'hBEEF;
    rep_flit = 16'hCAFE;
    req_ctrl = 2'b01;
    rep_ctrl = 2'b01;
    dc_download_state  = 2'b00;
    ic_download_state  = 2'b00;
    mem_download_state = 2'b00;
    lock_src = -1;
    lock_tgt = 0;
    last_rep = 1'b0;
    cnt = '{0, 0, 0};
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    step();

    for (int c = 0; c < 4000; c++) begin
      @(posedge clk);
      #1;
      do_rst = lock_src == 1 && $urandom_range(0, 99) < 3;
      rst = do_rst;
      if (do_rst) begin
        req_q.delete();
        rep_q.delete();
      end
      if (req_q.size() == 0 && $urandom_range(0, 1) == 1) push_pkt(1'b0);
      if (rep_q.size() == 0 && $urandom_range(0, 1) == 1) push_pkt(1'b1);
      drive(c);
      @(negedge clk);
      if (do_rst) begin
        lock_src = -1;
        last_rep = 1'b0;
        cnt = '{0, 0, 0};
      end else begin
        step();
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
